// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one 4-bit LFSR among NREQ requesters.
// Warms the LFSR after reset and range-limits each draw by rejection sampling with a bounded fallback.
module rng_arbiter #(
    parameter int NREQ          = 4,
    parameter int MAX_VAL       = 9,
    parameter int WARMUP_CYCLES = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] rsp_valid,
    output logic [3:0]      rsp_data,
    output logic            rng_enable,
    input  logic [3:0]      rng_value,
    output logic            ready,
    output logic            busy
);

    localparam int              IDX_W     = $clog2(NREQ);
    localparam logic [7:0]      WARM_N    = 8'(WARMUP_CYCLES);
    localparam logic [7:0]      WARM_LAST = 8'(WARMUP_CYCLES - 1);
    localparam logic [3:0]      MAX_V     = 4'(MAX_VAL);
    localparam logic [2:0]      RETRY_N   = 3'(MAX_RETRY);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    typedef enum logic [2:0] {
        WARMUP,
        IDLE,
        STEP,
        CHECK,
        DELIVER
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       warm_cnt, warm_cnt_nxt;
    logic [2:0]       retry, retry_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] grant, grant_nxt;
    logic             ready_r, ready_nxt;
    logic [3:0]       value, value_nxt;
    logic             value_load;
    logic             rng_step;

    // First set request at or after the pointer, wrapping from NREQ-1 to 0.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = p;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(p) + i) % NREQ;
            if (r[idx]) pick = IDX_W'(idx);
        end
        return pick;
    endfunction

    // Out-of-range fallback: always lands in 0..MAX_VAL since rng_value <= 15 < 2*(MAX_VAL+1).
    function automatic logic [3:0] fold(input logic [3:0] v);
        return v - 4'(MAX_VAL + 1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= WARMUP;
            warm_cnt <= '0;
            retry    <= '0;
            ptr      <= '0;
            grant    <= '0;
            ready_r  <= 1'b0;
        end else begin
            state    <= state_nxt;
            warm_cnt <= warm_cnt_nxt;
            retry    <= retry_nxt;
            ptr      <= ptr_nxt;
            grant    <= grant_nxt;
            ready_r  <= ready_nxt;
        end
    end

    // Delivered value is pure data and only observed in DELIVER, so it carries no reset.
    always_ff @(posedge clk) begin
        if (value_load) value <= value_nxt;
    end

    always_comb begin
        state_nxt    = state;
        warm_cnt_nxt = warm_cnt;
        retry_nxt    = retry;
        ptr_nxt      = ptr;
        grant_nxt    = grant;
        ready_nxt    = ready_r;
        value_nxt    = rng_value;
        value_load   = 1'b0;
        rng_step     = 1'b0;
        case (state)
            WARMUP: begin
                // One settling cycle after the last step before requests are looked at.
                if (warm_cnt == WARM_N) begin
                    state_nxt = IDLE;
                end else begin
                    rng_step     = 1'b1;
                    warm_cnt_nxt = warm_cnt + 8'd1;
                    if (warm_cnt == WARM_LAST) ready_nxt = 1'b1;
                end
            end
            IDLE: begin
                if (|req) begin
                    grant_nxt = rr_pick(req, ptr);
                    retry_nxt = '0;
                    state_nxt = STEP;
                end
            end
            STEP: begin
                rng_step  = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                if (rng_value <= MAX_V) begin
                    value_load = 1'b1;
                    state_nxt  = DELIVER;
                end else if (retry < RETRY_N) begin
                    retry_nxt = retry + 3'd1;
                    state_nxt = STEP;
                end else begin
                    value_load = 1'b1;
                    value_nxt  = fold(rng_value);
                    state_nxt  = DELIVER;
                end
            end
            DELIVER: begin
                ptr_nxt   = (grant == LAST_IDX) ? '0 : grant + IDX_W'(1);
                state_nxt = IDLE;
            end
            default: state_nxt = WARMUP;
        endcase
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = 4'd0;
        if (state == DELIVER) begin
            rsp_valid[grant] = 1'b1;
            rsp_data         = value;
        end
    end

    // Reset gating keeps the strobe low while reset holds the FSM in WARMUP.
    assign rng_enable = rng_step & ~reset;
    assign ready      = ready_r;
    assign busy       = (state == STEP) || (state == CHECK) || (state == DELIVER);

endmodule
